// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared definitions for the two-requester RAM arbiter: FSM state
//   encoding, requester count and the default memory geometry.
//   Optional build macro: RAM_ARB_RR_EN (selects round-robin arbitration
//   in ram_arbiter; fixed priority when undefined).
package ram_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int DEF_AW  = 3;
  localparam int DEF_DW  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RDW  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_arbiter_sp_ram.sv
// sp_ram
//   Single-port synchronous RAM, inferred as block RAM. One-cycle read
//   latency through a registered read port. Contents are not reset, so a
//   never-written word reads back as X in simulation.
//   Ports:
//     clk    clock
//     en     access enable (read or write)
//     we     1 = write, 0 = read
//     addr   word address (AW bits)
//     wdata  write data (DW bits)
//     rdata  registered read data, valid the cycle after a read access
module sp_ram #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Arbitrates two requesters onto one single-port RAM (sp_ram).
//   FSM: IDLE picks a winner and captures its command, ACC performs the
//   memory access (grant pulse), RDW returns read data (rvalid pulse).
//   A write takes 2 cycles (ACC, IDLE), a read 3 cycles (ACC, RDW, IDLE).
//   Build macro RAM_ARB_RR_EN: defined -> round-robin on conflict (a
//   priority pointer alternates after every grant); undefined -> fixed
//   priority, requester 0 wins, no pointer register.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     req_i[1:0]          per-requester request
//     we_i[1:0]           per-requester write enable
//     addr0_i, addr1_i    per-requester address
//     wdata0_i, wdata1_i  per-requester write data
//     gnt_o[1:0]          one-hot grant pulse (cycle of the memory access)
//     rvalid_o[1:0]       one-hot read-data-valid pulse
//     rdata_o             read data, holds last value between reads
//     busy_o              high while the FSM is not IDLE
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] we_i,
  input  logic [AW-1:0]      addr0_i,
  input  logic [AW-1:0]      addr1_i,
  input  logic [DW-1:0]      wdata0_i,
  input  logic [DW-1:0]      wdata1_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] rvalid_o,
  output logic [DW-1:0]      rdata_o,
  output logic               busy_o
);

  state_t             state_reg;
  logic               win_reg;
  logic               win_next;
  logic               we_reg;
  logic [AW-1:0]      addr_reg;
  logic [DW-1:0]      wdata_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [NUM_REQ-1:0] rvalid_reg;
  logic               busy_reg;
  logic [DW-1:0]      rdata_hold_reg;
  logic [NUM_REQ-1:0] gnt_next;
  logic [NUM_REQ-1:0] rvalid_next;
  logic [DW-1:0]      ram_rdata;
  logic               ram_en;

  logic [AW-1:0]      addr_arr  [NUM_REQ];
  logic [DW-1:0]      wdata_arr [NUM_REQ];

  assign addr_arr[0]  = addr0_i;
  assign addr_arr[1]  = addr1_i;
  assign wdata_arr[0] = wdata0_i;
  assign wdata_arr[1] = wdata1_i;

  // One-hot decode of the winner for the grant and rvalid pulses.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign gnt_next[gi]    = (win_next == 1'(gi));
      assign rvalid_next[gi] = (win_reg == 1'(gi));
    end
  endgenerate

`ifdef RAM_ARB_RR_EN
  // prio_reg names the requester that wins the next conflict; it flips to
  // the other requester on every grant.
  logic prio_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else if (state_reg == ACC) begin
      prio_reg <= ~win_reg;
    end
  end

  always_comb begin
    win_next = ~req_i[0];
    if (req_i == 2'b11) begin
      win_next = prio_reg;
    end
  end
`else
  // Requester 0 wins whenever it asks; otherwise requester 1.
  always_comb begin
    win_next = ~req_i[0];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      win_reg        <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      gnt_reg        <= '0;
      rvalid_reg     <= '0;
      busy_reg       <= 1'b0;
      rdata_hold_reg <= '0;
    end else begin
      gnt_reg    <= '0;
      rvalid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (|req_i) begin
            win_reg   <= win_next;
            we_reg    <= we_i[win_next];
            addr_reg  <= addr_arr[win_next];
            wdata_reg <= wdata_arr[win_next];
            gnt_reg   <= gnt_next;
            busy_reg  <= 1'b1;
            state_reg <= ACC;
          end else begin
            busy_reg  <= 1'b0;
          end
        end
        ACC: begin
          if (we_reg) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            rvalid_reg <= rvalid_next;
            busy_reg   <= 1'b1;
            state_reg  <= RDW;
          end
        end
        RDW: begin
          // Keep the returned word so rdata_o holds it after the pulse.
          rdata_hold_reg <= ram_rdata;
          busy_reg       <= 1'b0;
          state_reg      <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The RAM is only touched in ACC, so a reset that forces IDLE before
  // the commit edge also cancels a pending write.
  assign ram_en = (state_reg == ACC);

  sp_ram #(
    .AW (AW),
    .DW (DW)
  ) u_sp_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (we_reg),
    .addr  (addr_reg),
    .wdata (wdata_reg),
    .rdata (ram_rdata)
  );

  assign gnt_o    = gnt_reg;
  assign rvalid_o = rvalid_reg;
  assign busy_o   = busy_reg;
  // RAM output is live during the rvalid cycle; the held copy otherwise.
  assign rdata_o  = (|rvalid_reg) ? ram_rdata : rdata_hold_reg;

endmodule
